instruction_sequencer: RTL and testbench

//  Upstream feeder for cpu: buffers 16-bit instructions from a host (valid/ready), drives
//  cpu.current_instruction once per clock_in, and fills gaps with NOPs (16'h0000).

---
 rtl/instruction_sequencer.sv | 138 +++++++++++++
 tb/tb_instruction_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: buffers host instructions and feeds cpu one word per clock, inserting NOPs.
// Optional feature macro SEQ_OPERATE_PAD_EN: when defined, tensor-core operates are followed by OPERATE_GAP NOPs.
module instruction_sequencer #(
    parameter int DEPTH       = 16,
    parameter int BURST_WORDS = 5,
    parameter int OPERATE_GAP = 5
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic [15:0]            host_instruction_in,
    input  logic                   host_valid_in,
    output logic                   host_ready_out,
    output logic [15:0]            current_instruction_out,
    output logic                   busy_out,
    output logic [$clog2(DEPTH):0] fifo_count_out,
    output logic [1:0]             state_out
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] ISSUE      = 2'd1;
    localparam logic [1:0] BURST_DATA = 2'd2;
    localparam logic [1:0] PAD        = 2'd3;

    localparam logic [AW:0] DEPTH_C    = (AW+1)'(DEPTH);
    localparam logic [AW:0] BURST_NEED = (AW+1)'(BURST_WORDS + 1);
    localparam logic [7:0]  BURST_CNT  = 8'(BURST_WORDS);
    localparam logic [7:0]  GAP_CNT    = 8'(OPERATE_GAP);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [1:0]    r_state;
    logic [7:0]    r_cnt;
    logic [15:0]   r_out;

    logic          w_push;
    logic          w_pop;
    logic [15:0]   w_head;
    logic          w_is_bw;
    logic          w_is_br;
    logic          w_is_op;
    logic          w_pad_op;
    logic [1:0]    w_next_state;
    logic [7:0]    w_next_cnt;
    logic [15:0]   w_next_out;

    assign host_ready_out          = (r_count < DEPTH_C);
    assign w_push                  = host_valid_in && host_ready_out;
    assign w_head                  = r_mem[r_rd_ptr];
    assign current_instruction_out = r_out;
    assign fifo_count_out          = r_count;
    assign busy_out                = (r_state != IDLE) || (r_count != '0);
    assign state_out               = r_state;

    assign w_is_bw = (w_head[1:0] == 2'b11) && ((w_head[3:2] == 2'b01) || (w_head[3:2] == 2'b10));
    assign w_is_br = (w_head[1:0] == 2'b11) && (w_head[3:2] == 2'b00);
    assign w_is_op = (w_head[1:0] == 2'b10);

`ifdef SEQ_OPERATE_PAD_EN
    assign w_pad_op = w_is_op;
`else
    assign w_pad_op = 1'b0;
`endif

    always_comb begin
        w_pop        = 1'b0;
        w_next_out   = 16'h0000;
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            BURST_DATA: begin
                // Payload is forwarded raw; enough words were guaranteed before the header left.
                w_pop      = 1'b1;
                w_next_out = w_head;
                w_next_cnt = r_cnt - 8'd1;
                if (r_cnt == 8'd1) w_next_state = ISSUE;
            end
            PAD: begin
                w_next_cnt = r_cnt - 8'd1;
                if (r_cnt == 8'd1) w_next_state = ISSUE;
            end
            default: begin
                if (r_count == '0) begin
                    w_next_state = IDLE;
                end else if (w_is_bw) begin
                    // Hold the header until header plus full payload are buffered.
                    if (r_count >= BURST_NEED) begin
                        w_pop        = 1'b1;
                        w_next_out   = w_head;
                        w_next_state = BURST_DATA;
                        w_next_cnt   = BURST_CNT;
                    end else begin
                        w_next_state = ISSUE;
                    end
                end else if (w_is_br) begin
                    w_pop        = 1'b1;
                    w_next_out   = w_head;
                    w_next_state = PAD;
                    w_next_cnt   = BURST_CNT;
                end else if (w_pad_op) begin
                    w_pop        = 1'b1;
                    w_next_out   = w_head;
                    w_next_state = PAD;
                    w_next_cnt   = GAP_CNT;
                end else begin
                    w_pop        = 1'b1;
                    w_next_out   = w_head;
                    w_next_state = ISSUE;
                end
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (w_push) r_mem[r_wr_ptr] <= host_instruction_in;
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= IDLE;
            r_cnt    <= 8'd0;
            r_out    <= 16'h0000;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_out   <= w_next_out;
        end
    end
endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized and directed bench for instruction_sequencer against a queue-based reference model.
module tb_instruction_sequencer;
    localparam int DEPTH = 16;
    localparam int BW    = 5;
    localparam int GAP   = 5;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b1;
    logic [15:0] host_instruction_in = 16'h0000;
    logic        host_valid_in = 1'b0;
    logic        host_ready_out;
    logic [15:0] current_instruction_out;
    logic        busy_out;
    logic [4:0]  fifo_count_out;
    logic [1:0]  state_out;

    always #5 clock_in = ~clock_in;

    instruction_sequencer #(.DEPTH(DEPTH), .BURST_WORDS(BW), .OPERATE_GAP(GAP)) dut (
        .clock_in                (clock_in),
        .reset_in                (reset_in),
        .host_instruction_in     (host_instruction_in),
        .host_valid_in           (host_valid_in),
        .host_ready_out          (host_ready_out),
        .current_instruction_out (current_instruction_out),
        .busy_out                (busy_out),
        .fifo_count_out          (fifo_count_out),
        .state_out               (state_out)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    int          m_pad    = 0;
    int          m_data   = 0;
    logic [15:0] m_out    = 16'h0000;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a word queue plus "NOPs still owed" and "payload words still owed".
    task automatic model_step(input logic rst, input logic vld, input logic [15:0] d);
        logic [15:0] h;
        int          pre;
        bit          rdy;
        if (rst) begin
            exp_q.delete();
            m_pad  = 0;
            m_data = 0;
            m_out  = 16'h0000;
        end else begin
            pre = exp_q.size();
            rdy = (pre < DEPTH);
            if (m_pad > 0) begin
                m_out = 16'h0000;
                m_pad--;
            end else if (m_data > 0) begin
                m_out = exp_q.pop_front();
                m_data--;
            end else if (pre == 0) begin
                m_out = 16'h0000;
            end else begin
                h = exp_q[0];
                if (h[1:0] == 2'b11 && (h[3:2] == 2'b01 || h[3:2] == 2'b10)) begin
                    if (pre >= BW + 1) begin
                        m_out  = exp_q.pop_front();
                        m_data = BW;
                    end else begin
                        m_out = 16'h0000;
                    end
                end else if (h[1:0] == 2'b11 && h[3:2] == 2'b00) begin
                    m_out = exp_q.pop_front();
                    m_pad = BW;
                end else if (h[1:0] == 2'b10) begin
                    m_out = exp_q.pop_front();
`ifdef SEQ_OPERATE_PAD_EN
                    m_pad = GAP;
`endif
                end else begin
                    m_out = exp_q.pop_front();
                end
            end
            if (vld && rdy) exp_q.push_back(d);
        end
    endtask

    task automatic step(input logic rst, input logic vld, input logic [15:0] d);
        reset_in            = rst;
        host_valid_in       = vld;
        host_instruction_in = d;
        @(posedge clock_in);
        model_step(rst, vld, d);
        #1;
        check_eq("out", {16'h0, current_instruction_out}, {16'h0, m_out});
        check_eq("count", {27'h0, fifo_count_out}, 32'(exp_q.size()));
        check_eq("ready", {31'h0, host_ready_out}, {31'h0, (exp_q.size() < DEPTH)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000);
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        int          k;
        w = 16'($urandom);
        k = $urandom_range(0, 9);
        case (k)
            0:       w[3:0] = 4'b0111;
            1:       w[3:0] = 4'b1011;
            2:       w[3:0] = 4'b0011;
            3:       w[1:0] = 2'b10;
            4:       w = 16'h000C;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        step(1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 16'h5555);
        check_eq("busy_reset", {31'h0, busy_out}, 32'h0);
        step(1'b0, 1'b1, 16'h1231);
        step(1'b0, 1'b1, 16'h0022);
        idle(3);

        step(1'b0, 1'b1, 16'h0007);
        idle(3);
        check_eq("bw_held", {27'h0, fifo_count_out}, 32'h1);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 16'hA000 + 16'(i));
        idle(8);

        step(1'b0, 1'b1, 16'h0003);
        step(1'b0, 1'b1, 16'h1231);
        idle(8);

        step(1'b0, 1'b1, 16'h0002);
        step(1'b0, 1'b1, 16'h0002);
        idle(14);

        for (int i = 0; i < 60 && exp_q.size() < DEPTH; i++) step(1'b0, 1'b1, 16'h0003);
        check_eq("full_ready", {31'h0, host_ready_out}, 32'h0);
        step(1'b0, 1'b1, 16'h1111);
        idle(120);

        step(1'b0, 1'b1, 16'h0007);
        step(1'b0, 1'b1, 16'hB001);
        step(1'b0, 1'b1, 16'hB002);
        step(1'b0, 1'b1, 16'h000C);
        step(1'b0, 1'b1, 16'hB004);
        step(1'b0, 1'b1, 16'hB005);
        idle(2);
        step(1'b1, 1'b0, 16'h0000);
        check_eq("busy_midburst_reset", {31'h0, busy_out}, 32'h0);
        idle(8);

        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), rand_word());
        end

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0000);
        idle(150);
        check_eq("busy_drained", {31'h0, busy_out}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
